// File: rtl/adc_trigger.sv
// adc_trigger: paces SAR ADC conversions and issues a one-cycle readout trigger.
// A conversion starts after `divider` ready WAIT cycles. It ends on a busy falling
// edge, or it is abandoned after BUSY_TIMEOUT cycles. A trigger is raised once
// every max(averages,1) completed conversions. `last` parks the sequencer in HALT
// and cfg[1] re-arms it. cfg[0] is a level-sensitive soft reset.
module adc_trigger #(
    parameter int unsigned BUSY_TIMEOUT = 32'd1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] divider,
    input  logic [31:0] averages,
    input  logic [31:0] cfg,
    input  logic        ready,
    input  logic        last,
    input  logic        busy,
    output logic        cnv,
    output logic        trigger
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CONVERT = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 32'd1);

    state_t      state_r, state_s;
    logic [31:0] count_r, count_s;
    logic [31:0] avg_cnt_r, avg_cnt_s;
    logic [15:0] tmo_r, tmo_s;
    logic        busy_q_r;
    logic        seen_busy_r, seen_busy_s;
    logic        last_pend_r, last_pend_s;
    logic        cnv_r, cnv_s;
    logic        trigger_r, trigger_s;

    logic        srst_s;
    logic        rearm_s;
    logic [31:0] div_last_s;
    logic [31:0] avg_target_s;
    logic [31:0] avg_next_s;
    logic        eoc_s;
    logic        unused_cfg_s;

    assign srst_s       = cfg[0];
    assign rearm_s      = cfg[1];
    assign unused_cfg_s = ^cfg[31:2];
    assign div_last_s   = divider - 32'd1;
    assign avg_target_s = (averages == 32'd0) ? 32'd1 : averages;
    assign avg_next_s   = avg_cnt_r + 32'd1;
    // End of conversion: busy seen high during this conversion and now falling.
    assign eoc_s        = busy_q_r & ~busy & seen_busy_r;

    // Next-state and next-output logic for the conversion sequencer.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        avg_cnt_s   = avg_cnt_r;
        tmo_s       = tmo_r;
        seen_busy_s = seen_busy_r;
        last_pend_s = last_pend_r;
        cnv_s       = 1'b0;
        trigger_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s   = ST_WAIT;
                count_s   = 32'd0;
                avg_cnt_s = 32'd0;
            end
            ST_WAIT: begin
                if (last) begin
                    state_s = ST_HALT;
                    count_s = 32'd0;
                end else if (ready && (divider != 32'd0)) begin
                    // >= so that shrinking divider below count starts at once
                    if (count_r >= div_last_s) begin
                        cnv_s       = 1'b1;
                        count_s     = 32'd0;
                        tmo_s       = 16'd0;
                        seen_busy_s = 1'b0;
                        last_pend_s = 1'b0;
                        state_s     = ST_CONVERT;
                    end else begin
                        count_s = count_r + 32'd1;
                    end
                end else begin
                    // not ready: pacing freezes; disabled: pacing restarts
                    count_s = (divider == 32'd0) ? 32'd0 : count_r;
                end
            end
            ST_CONVERT: begin
                cnv_s = 1'b1;
                if (busy) begin
                    seen_busy_s = 1'b1;
                end else begin
                    seen_busy_s = seen_busy_r;
                end
                if (last) begin
                    last_pend_s = 1'b1;
                end else begin
                    last_pend_s = last_pend_r;
                end
                if (eoc_s) begin
                    cnv_s   = 1'b0;
                    state_s = (last_pend_r || last) ? ST_HALT : ST_WAIT;
                    if (avg_next_s >= avg_target_s) begin
                        trigger_s = 1'b1;
                        avg_cnt_s = 32'd0;
                    end else begin
                        avg_cnt_s = avg_next_s;
                    end
                end else if (tmo_r >= TMO_LAST) begin
                    cnv_s   = 1'b0;
                    state_s = (last_pend_r || last) ? ST_HALT : ST_WAIT;
                end else begin
                    tmo_s = tmo_r + 16'd1;
                end
            end
            ST_HALT: begin
                count_s   = 32'd0;
                avg_cnt_s = 32'd0;
                if (rearm_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with async reset and cfg[0] soft reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            count_r     <= 32'd0;
            avg_cnt_r   <= 32'd0;
            tmo_r       <= 16'd0;
            busy_q_r    <= 1'b0;
            seen_busy_r <= 1'b0;
            last_pend_r <= 1'b0;
            cnv_r       <= 1'b0;
            trigger_r   <= 1'b0;
        end else if (srst_s) begin
            state_r     <= ST_IDLE;
            count_r     <= 32'd0;
            avg_cnt_r   <= 32'd0;
            tmo_r       <= 16'd0;
            busy_q_r    <= 1'b0;
            seen_busy_r <= 1'b0;
            last_pend_r <= 1'b0;
            cnv_r       <= 1'b0;
            trigger_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            avg_cnt_r   <= avg_cnt_s;
            tmo_r       <= tmo_s;
            busy_q_r    <= busy;
            seen_busy_r <= seen_busy_s;
            last_pend_r <= last_pend_s;
            cnv_r       <= cnv_s;
            trigger_r   <= trigger_s;
        end
    end

    assign cnv     = cnv_r;
    assign trigger = trigger_r;

endmodule

// File: tb/tb_adc_trigger.sv
// Bench for adc_trigger: an ADC model answers each cnv rise with a random busy
// pulse and queues the expected conversion outcome. A monitor pops the queue on
// every cnv fall and checks the high time and the trigger.
module tb_adc_trigger;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] divider = 32'd50;
    logic [31:0] averages = 32'd1;
    logic [31:0] cfg = 32'd0;
    logic        ready = 1'b0;
    logic        last = 1'b0;
    logic        busy;
    logic        cnv;
    logic        trigger;

    adc_trigger #(.BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .divider(divider), .averages(averages),
        .cfg(cfg), .ready(ready), .last(last), .busy(busy),
        .cnv(cnv), .trigger(trigger)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int n_rise = 0, n_fall = 0, n_trig = 0;
    int disturb = 0;     // bumped whenever the divider-gap rule is suspended
    int abort_cnt = 0;   // bumped before a reset kills a conversion
    int model_done = 0;  // completed conversions since last trigger/halt/reset
    bit adc_timeout = 1'b0;

    typedef struct { int len; bit trig; } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ADC model plus reference: decides each conversion's outcome at cnv rise.
    initial begin
        bit prev;
        int b, tgt;
        exp_t e;
        prev = 1'b0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (cnv && !prev) begin
                if (adc_timeout) begin
                    e.len = TMO; e.trig = 1'b0;
                    exp_q.push_back(e);
                end else begin
                    b = $urandom_range(3, 20);
                    tgt = (averages == 32'd0) ? 1 : int'(averages);
                    model_done++;
                    e.len = b + 1;
                    e.trig = (model_done >= tgt);
                    if (e.trig) model_done = 0;
                    exp_q.push_back(e);
                    busy = 1'b1;
                    repeat (b) @(negedge clk);
                    busy = 1'b0;
                end
            end
            prev = cnv;
        end
    end

    // Monitor: checks gaps, conversion length and trigger against the queue.
    initial begin
        bit prev, have_fall;
        int rise_cyc, fall_cyc, rise_abort, fall_dist;
        exp_t e;
        prev = 1'b0; have_fall = 1'b0;
        rise_cyc = 0; fall_cyc = 0; rise_abort = 0; fall_dist = 0;
        forever begin
            @(negedge clk);
            if (trigger) n_trig++;
            if (cnv && !prev) begin
                n_rise++;
                rise_cyc = cyc;
                rise_abort = abort_cnt;
                if (have_fall && fall_dist == disturb)
                    check("wait_gap", cyc - fall_cyc, divider);
            end
            if (!cnv && prev) begin
                n_fall++;
                fall_cyc = cyc;
                fall_dist = disturb;
                have_fall = 1'b1;
                check("conversion_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (rise_abort != abort_cnt) begin
                        have_fall = 1'b0;
                    end else begin
                        check("cnv_high_cycles", cyc - rise_cyc, e.len);
                        check("trigger_at_eoc", trigger, e.trig);
                    end
                end
            end else begin
                check("no_stray_trigger", trigger, 0);
            end
            prev = cnv;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_falls(input int k);
        int target, g;
        target = n_fall + k; g = 0;
        while (n_fall < target && g < 4000) begin tick(); g++; end
        check("falls_reached", n_fall >= target, 1);
    endtask

    task automatic wait_rise();
        int target, g;
        target = n_rise + 1; g = 0;
        while (n_rise < target && g < 4000) begin tick(); g++; end
        check("rise_reached", n_rise >= target, 1);
    endtask

    task automatic wait_trig();
        int target, g;
        target = n_trig + 1; g = 0;
        while (n_trig < target && g < 4000) begin tick(); g++; end
        check("trigger_reached", n_trig >= target, 1);
    endtask

    task automatic cycles_to_rise(output int n);
        n = 0;
        while (!cnv && n < 2000) begin tick(); n++; end
    endtask

    task automatic halt_and_rearm(input string tag);
        int r0, n;
        r0 = n_rise;
        repeat (200) tick();
        check({tag, "_halt_no_cnv"}, n_rise - r0, 0);
        disturb++;
        cfg = 32'd2;
        tick();
        cfg = 32'd0;
        cycles_to_rise(n);
        check({tag, "_rearm_latency"}, n + 1, divider + 1);
    endtask

    // Directed phases with randomized ADC timing and parameters.
    initial begin
        int n, t0;
        repeat (3) tick();
        check("reset_cnv", cnv, 0);
        check("reset_trigger", trigger, 0);
        resetn = 1'b1;

        // ready low: nothing happens; then first conversion after divider cycles
        repeat (60) tick();
        check("no_cnv_without_ready", n_rise, 0);
        ready = 1'b1;
        cycles_to_rise(n);
        check("first_cnv_latency", n, divider);

        // averages=1: a trigger per conversion
        t0 = n_trig;
        wait_falls(5);
        check("avg1_triggers", n_trig - t0, 5);

        // averages=4: one trigger per four conversions
        averages = 32'd4;
        t0 = n_trig;
        wait_falls(8);
        check("avg4_triggers", n_trig - t0, 2);

        // averages=0 behaves as 1
        averages = 32'd0;
        t0 = n_trig;
        wait_falls(3);
        check("avg0_triggers", n_trig - t0, 3);

        // random short dividers and averages
        repeat (6) begin
            divider = 32'($urandom_range(1, 10));
            averages = 32'($urandom_range(1, 3));
            wait_falls(1);
        end
        divider = 32'd50;
        averages = 32'd2;

        // last pulsed two cycles after a trigger: halt, then re-arm
        wait_trig();
        tick(); tick();
        last = 1'b1; disturb++;
        tick();
        last = 1'b0;
        model_done = 0;
        halt_and_rearm("last_wait");

        // last during a conversion whose completion is due to trigger
        wait_falls(1);
        wait_rise();
        repeat (3) tick();
        last = 1'b1; disturb++;
        tick();
        last = 1'b0;
        t0 = n_trig;
        wait_falls(1);
        check("last_eoc_trigger", n_trig - t0, 1);
        model_done = 0;
        halt_and_rearm("last_cnv");

        // busy never rises: timeout, no trigger, averaging count kept
        averages = 32'd3;
        wait_falls(1);
        adc_timeout = 1'b1;
        t0 = n_trig;
        wait_falls(2);
        check("timeout_no_trigger", n_trig - t0, 0);
        adc_timeout = 1'b0;
        wait_falls(4);

        // soft reset mid-conversion
        wait_rise();
        repeat (5) tick();
        abort_cnt++; disturb++;
        cfg = 32'd1;
        tick();
        check("srst_cnv", cnv, 0);
        check("srst_trigger", trigger, 0);
        repeat (3) tick();
        check("srst_hold_cnv", cnv, 0);
        model_done = 0;
        cfg = 32'd0;
        cycles_to_rise(n);
        check("srst_restart_latency", n, divider + 1);

        // async reset mid-conversion
        repeat (4) tick();
        abort_cnt++; disturb++;
        #3 resetn = 1'b0;
        #1;
        check("async_reset_cnv", cnv, 0);
        check("async_reset_trigger", trigger, 0);
        tick();
        resetn = 1'b1;
        model_done = 0;
        cycles_to_rise(n);
        check("reset_restart_latency", n, divider + 1);

        wait_falls(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
